decode_stage: RTL

// - IF->ID pipeline stage: buffers fetched instructions in a 2-entry skid buffer and decodes the
//   RV32I opcode into immg_op, register indices and an illegal flag.
// - Sits between fetch and the immediate_generator / register-file read of the execute stage.
// - Outputs a registered instr + immg_op pair that the immediate_generator consumes directly.

---
 rtl/decode_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage
// IF->ID pipeline stage. Incoming fetch words are decoded on entry (immediate
// format, illegal flag) and held in a two-entry skid buffer: a main register
// that drives the id_* outputs and a skid register that catches one word when
// execute stalls. if_ready comes from a flop, so there is no combinational path
// from id_ready back to if_ready.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             drop everything buffered (branch redirect), wins over transfers
//   if_valid/if_ready fetch-side handshake, if_instr/if_pc its payload
//   id_valid/id_ready execute-side handshake
//   id_instr/id_pc    buffered word and its PC
//   id_immg_op        immediate format for the immediate_generator
//   id_rs1/rs2/rd     register indices sliced from id_instr
//   id_illegal        unsupported opcode or instr[1:0] != 2'b11
//   dbg_state         current buffer state (0 EMPTY, 1 FULL, 2 SKID)
//
// Handshake: a word moves when valid && ready on the same rising edge. The
// producer holds its payload stable while valid && !ready, and valid is never
// withdrawn without a transfer or a flush.

`ifndef INSTR_BUS
`define INSTR_BUS [31:0]
`endif
`ifndef IMMG_OP_BUS
`define IMMG_OP_BUS [2:0]
`endif
`ifndef IMMG_OP_I
`define IMMG_OP_I 3'd0
`define IMMG_OP_S 3'd1
`define IMMG_OP_B 3'd2
`define IMMG_OP_U 3'd3
`define IMMG_OP_J 3'd4
`endif

module decode_stage #(
   parameter int PC_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic `INSTR_BUS   if_instr,
   input  logic [PC_W-1:0]   if_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic `INSTR_BUS   id_instr,
   output logic [PC_W-1:0]   id_pc,
   output logic `IMMG_OP_BUS id_immg_op,
   output logic [4:0]        id_rs1,
   output logic [4:0]        id_rs2,
   output logic [4:0]        id_rd,
   output logic              id_illegal,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t state_q, state_d;
   logic   ready_q;

   logic `INSTR_BUS   main_instr, skid_instr;
   logic [PC_W-1:0]   main_pc, skid_pc;
   logic `IMMG_OP_BUS main_op, skid_op;
   logic              main_ill, skid_ill;

   logic `IMMG_OP_BUS in_op;
   logic              in_ill;

   logic accept, out;
   logic load_main_in, load_main_skid, load_skid;

   // flush removes both transfers from the cycle it is asserted in
   assign accept = if_valid && ready_q && !flush;
   assign out    = id_valid && id_ready && !flush;

   // decode of the incoming word, stored alongside it
   always_comb begin
      in_op  = `IMMG_OP_I;
      in_ill = 1'b0;
      case (if_instr[6:0])
         7'b0110111, 7'b0010111: in_op = `IMMG_OP_U;
         7'b1101111:             in_op = `IMMG_OP_J;
         7'b1100011:             in_op = `IMMG_OP_B;
         7'b0100011:             in_op = `IMMG_OP_S;
         7'b1100111, 7'b0000011, 7'b0010011,
         7'b0001111, 7'b1110011, 7'b0110011: in_op = `IMMG_OP_I;
         default:                in_ill = 1'b1;
      endcase
      if (if_instr[1:0] != 2'b11) in_ill = 1'b1;
   end

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d      = FULL;
               load_main_in = 1'b1;
            end
         end
         FULL: begin
            if (accept && out) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_d   = SKID;
               load_skid = 1'b1;
            end else if (out) begin
               state_d = EMPTY;
            end
         end
         SKID: begin
            // if_ready is low here, so nothing can be accepted
            if (out) begin
               state_d        = FULL;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         ready_q    <= 1'b1;
         main_instr <= NOP;
         main_pc    <= '0;
         main_op    <= `IMMG_OP_I;
         main_ill   <= 1'b0;
         skid_instr <= NOP;
         skid_pc    <= '0;
         skid_op    <= `IMMG_OP_I;
         skid_ill   <= 1'b0;
      end else begin
         state_q <= state_d;
         // registered copy of "next state is not SKID"
         ready_q <= (state_d != SKID);
         if (load_main_in) begin
            main_instr <= if_instr;
            main_pc    <= if_pc;
            main_op    <= in_op;
            main_ill   <= in_ill;
         end else if (load_main_skid) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
            main_op    <= skid_op;
            main_ill   <= skid_ill;
         end
         if (load_skid) begin
            skid_instr <= if_instr;
            skid_pc    <= if_pc;
            skid_op    <= in_op;
            skid_ill   <= in_ill;
         end
      end
   end

   assign if_ready   = ready_q;
   assign id_valid   = (state_q != EMPTY);
   assign id_instr   = main_instr;
   assign id_pc      = main_pc;
   assign id_immg_op = main_op;
   assign id_illegal = main_ill;
   assign id_rs1     = main_instr[19:15];
   assign id_rs2     = main_instr[24:20];
   assign id_rd      = main_instr[11:7];
   assign dbg_state  = state_q;

endmodule
